// File: rtl/avg_pkg.sv
// rtl/avg_pkg.sv - shared widths and group state type for the averaging RAM writer
package avg_pkg;

   localparam int AVG_DATA_W = 8;
   localparam int AVG_NUM    = 4;
   localparam int AVG_ADDR_W = 9;

   localparam int CNT_W = $clog2(AVG_NUM);
   localparam int ACC_W = AVG_DATA_W + CNT_W;

   typedef enum logic {
      GRP_EMPTY,
      GRP_FILLING
   } grp_state_t;

endpackage

// File: rtl/ram_addr_gen.sv
// rtl/ram_addr_gen.sv - result RAM write address counter with sticky wrap flag
module ram_addr_gen
   import avg_pkg::*;
#(
   parameter int ADDR_W = AVG_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_i,
   input  logic              clr_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              wrapped_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wrapped_q, wrapped_d;

   // advance after each write pulse; clear beats the advance
   always_comb begin
      addr_d    = addr_q;
      wrapped_d = wrapped_q;
      if (clr_i) begin
         addr_d    = '0;
         wrapped_d = 1'b0;
      end else if (wr_i) begin
         addr_d = addr_q + ADDR_W'(1);
         if (&addr_q) begin
            wrapped_d = 1'b1;
         end
      end
   end

   // address and wrap state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q    <= '0;
         wrapped_q <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign addr_o    = addr_q;
   assign wrapped_o = wrapped_q;

endmodule

// File: rtl/avg_ram_writer.sv
// rtl/avg_ram_writer.sv - sums groups of FIFO bytes and writes their averages to RAM
module avg_ram_writer
   import avg_pkg::*;
#(
   parameter int DATA_W  = AVG_DATA_W,
   parameter int NUM_AVG = AVG_NUM,
   parameter int ADDR_W  = AVG_ADDR_W
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       rd_fifo,
   input  logic [DATA_W-1:0]          fifo_data,
   input  logic                       ram_clr,
   output logic                       ram_wr,
   output logic [ADDR_W-1:0]          ram_addr,
   output logic [DATA_W-1:0]          ram_wr_data,
   output logic [$clog2(NUM_AVG)-1:0] grp_cnt,
   output logic                       ram_wrapped
);

   // package widths describe the default configuration; other sizes derive their own
   localparam int GC_W  = (NUM_AVG == AVG_NUM) ? CNT_W : $clog2(NUM_AVG);
   localparam int SUM_W = (NUM_AVG == AVG_NUM && DATA_W == AVG_DATA_W) ? ACC_W : DATA_W + GC_W;
   localparam logic [GC_W-1:0] LAST_CNT = GC_W'(NUM_AVG - 1);

   logic              smp_vld_q;
   logic              take;
   grp_state_t        state_q, state_d;
   logic [GC_W-1:0]   cnt_q, cnt_d;
   logic [SUM_W-1:0]  acc_q, acc_d;
   logic [SUM_W-1:0]  sum;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   // a sample coinciding with ram_clr is dropped
   assign take = smp_vld_q & ~ram_clr;
   // first sample of a group loads, later samples accumulate
   assign sum  = ((cnt_q == '0) ? '0 : acc_q) + SUM_W'(fifo_data);

   // group FSM, accumulator and average write generation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      wr_d      = 1'b0;
      wr_data_d = wr_data_q;
      if (ram_clr) begin
         state_d = GRP_EMPTY;
         cnt_d   = '0;
         acc_d   = '0;
      end else if (take) begin
         acc_d = sum;
         case (state_q)
            GRP_EMPTY: begin
               state_d = GRP_FILLING;
               cnt_d   = GC_W'(1);
            end
            default: begin
               if (cnt_q == LAST_CNT) begin
                  state_d   = GRP_EMPTY;
                  cnt_d     = '0;
                  wr_d      = 1'b1;
                  wr_data_d = sum[SUM_W-1:GC_W];
               end else begin
                  cnt_d = cnt_q + GC_W'(1);
               end
            end
         endcase
      end
   end

   // state registers; smp_vld tracks the FIFO read latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         smp_vld_q <= 1'b0;
         state_q   <= GRP_EMPTY;
         cnt_q     <= '0;
         acc_q     <= '0;
         wr_q      <= 1'b0;
         wr_data_q <= '0;
      end else begin
         smp_vld_q <= rd_fifo;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         wr_q      <= wr_d;
         wr_data_q <= wr_data_d;
      end
   end

   ram_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_i      (wr_q),
      .clr_i     (ram_clr),
      .addr_o    (ram_addr),
      .wrapped_o (ram_wrapped)
   );

   assign ram_wr      = wr_q;
   assign ram_wr_data = wr_data_q;
   assign grp_cnt     = cnt_q;

endmodule

// File: doc/avg_ram_writer.md
# avg_ram_writer

Datapath stage downstream of the 50 MHz FIFO read control in the 50 MHz subsystem. It captures each byte popped from the clock-crossing FIFO and sums groups of NUM_AVG bytes. It writes the truncated average of each group to the result RAM at an auto-incrementing address and reports occupancy and wrap status to the host side. It runs in lock-step with the FIFO read strobe and never stalls.

## Interface
- DATA_W, 8, width of FIFO bytes and RAM words
- NUM_AVG, 4, samples per average; power of two, 2..16
- ADDR_W, 9, RAM address width (depth 2^ADDR_W)

Ports:
- clk  in  1  50 MHz clock
- reset_n  in  1  reset, asynchronous, active-low
- rd_fifo  in  1  read strobe issued to FIFO this cycle
- fifo_data  in  DATA_W  FIFO read data, valid the cycle after rd_fifo
- ram_clr  in  1  synchronous clear of group and address state
- ram_wr  out  1  RAM write enable, single-cycle pulse per average
- ram_addr  out  ADDR_W  RAM write address, stable while ram_wr high
- ram_wr_data  out  DATA_W  average value
- grp_cnt  out  log2(NUM_AVG)  samples accumulated in current group
- ram_wrapped  out  1  sticky: address has wrapped at least once

## Operation
- Capture: `smp_vld` is rd_fifo delayed one cycle. fifo_data is taken only when smp_vld = 1.
- Accumulator width is DATA_W + log2(NUM_AVG), so it never overflows.
  - A sample with grp_cnt = 0 loads the accumulator.
  - Any other sample adds to it.
- Group FSM has two states:
  - EMPTY (grp_cnt = 0): a sample moves it to FILLING with grp_cnt = 1.
  - FILLING: each sample increments grp_cnt.
  - The sample arriving at grp_cnt = NUM_AVG-1 completes the group. The FSM returns to EMPTY with grp_cnt = 0.
- On group completion: register ram_wr_data = (acc + sample) >> log2(NUM_AVG), truncating, no rounding, and assert ram_wr next cycle.
- Address:
  - ram_addr increments by 1 in the cycle after each ram_wr pulse.
  - It wraps from 2^ADDR_W-1 to 0. The wrap sets ram_wrapped, which stays set until ram_clr or reset.
- Back-to-back groups: a sample arriving in the same cycle as ram_wr belongs to the next group. There are no bubbles and no dropped samples.
- ram_clr has priority over everything. Next cycle:
  - grp_cnt = 0, accumulator = 0, ram_addr = 0, ram_wrapped = 0, ram_wr = 0.
  - A pending average write is cancelled.
  - A sample whose smp_vld coincides with ram_clr is discarded.
- Reset values: ram_wr 0, ram_addr 0, ram_wr_data 0, grp_cnt 0, ram_wrapped 0, FSM EMPTY, smp_vld 0.
- Reset mid-group discards the partial sum. No partial average is ever written.

## Timing
- rd_fifo for the final sample of a group asserted in cycle t:
  - data sampled at the end of t+1;
  - ram_wr high during t+2 with ram_addr = A;
  - ram_addr = A+1 from t+3.
- Maximum throughput: one sample per cycle and one write every NUM_AVG cycles.
- All outputs are registered, with no combinational path from inputs to outputs.
- ram_wr is never high for two consecutive cycles when NUM_AVG ≥ 2.

## Structure
- Shared package `avg_pkg` holds:
  - localparams ACC_W = DATA_W + $clog2(NUM_AVG) and CNT_W = $clog2(NUM_AVG);
  - the grp_state_t enum {GRP_EMPTY, GRP_FILLING}.
- One natural sub-module, `ram_addr_gen`: the address counter with wrap detect, sticky ram_wrapped and ram_clr. Its inputs are the ram_wr pulse and ram_clr.
- Accumulator and group FSM stay in the top module.

## Test plan
- Four samples 0x10, 0x20, 0x30, 0x40 on consecutive rd_fifo cycles -> single ram_wr, data 0x28 at addr 0, 2 cycles after the last rd_fifo; grp_cnt returns to 0.
- Four samples 0xFF each -> data 0xFF with no overflow. Samples 0x01, 0x01, 0x01, 0x02 -> data 0x01 (truncation).
- rd_fifo held high for 12 cycles with fifo_data incrementing from 0 -> writes 0x01, 0x05, 0x09 at addrs 0, 1, 2, with no gaps and no lost samples.
- 2^ADDR_W = 512 groups, then one more -> ram_wrapped rises when ram_addr goes 511 -> 0; group 513 is written at addr 0.
- Two samples, then ram_clr, then four samples of 0x08 -> no write for the partial group; one write of 0x08 at addr 0. ram_clr asserted in the ram_wr-pending cycle -> write suppressed.
- reset_n pulsed low mid-group (grp_cnt = 3) -> all outputs at reset values immediately; the next full group writes at addr 0.
